// File: rtl/alu_if.sv
// Operand/result bundle for the RV32I ALU. The master drives the operands and
// decode fields; the slave (the ALU) returns the result.
interface alu_if;
  logic [31:0] in1;
  logic [31:0] in2;
  logic        is_imm;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] out;

  modport master (
    output in1,
    output in2,
    output is_imm,
    output funct3,
    output funct7,
    input  out
  );

  modport slave (
    input  in1,
    input  in2,
    input  is_imm,
    input  funct3,
    input  funct7,
    output out
  );
endinterface

// File: rtl/alu.sv
// RV32I integer ALU (OP and OP-IMM). Define ALU_OUT_REG_EN to register the
// result (1-cycle latency, async active-low reset to 0); otherwise purely combinational.
module alu (
  input  logic clk,
  input  logic rst,
  alu_if.slave bus
);

  function automatic logic [31:0] alu_calc(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic        is_imm,
    input logic [2:0]  funct3,
    input logic        f7_bit5
  );
    logic [31:0] r;
    logic [4:0]  shamt;
    shamt = b[4:0];
    case (funct3)
      3'b000: begin
        // OP-IMM has no SUB form, so funct7 only matters for register-register
        if (!is_imm && f7_bit5) begin
          r = a - b;
        end else begin
          r = a + b;
        end
      end
      3'b001: r = a << shamt;
      3'b010: r = {31'd0, ($signed(a) < $signed(b))};
      3'b011: r = {31'd0, (a < b)};
      3'b100: r = a ^ b;
      3'b101: begin
        if (f7_bit5) begin
          r = $unsigned($signed(a) >>> shamt);
        end else begin
          r = a >> shamt;
        end
      end
      3'b110: r = a | b;
      3'b111: r = a & b;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  logic [31:0] result_s;
  logic        unused_funct7_s;

  assign unused_funct7_s = &{1'b0, bus.funct7[6], bus.funct7[4:0]};

  // Operation decode and evaluation
  always_comb begin
    result_s = alu_calc(bus.in1, bus.in2, bus.is_imm, bus.funct3, bus.funct7[5]);
  end

`ifdef ALU_OUT_REG_EN
  logic [31:0] out_r;

  // Result register; reset discards any pending result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_r <= 32'd0;
    end else begin
      out_r <= result_s;
    end
  end

  assign bus.out = out_r;
`else
  logic unused_clk_rst_s;

  assign unused_clk_rst_s = &{1'b0, clk, rst};
  assign bus.out = result_s;
`endif

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: vector table plus reset and back-to-back
// sequences; adapts its timing to whether ALU_OUT_REG_EN is defined.
module tb_alu;

  typedef struct {
    logic [31:0] in1;
    logic [31:0] in2;
    logic        is_imm;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] exp;
  } vec_t;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  logic [31:0] exp_q[$];
  vec_t vecs[18];
  vec_t b2b[3];

  alu_if bus_if ();

  alu u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus_if.in1    = v.in1;
    bus_if.in2    = v.in2;
    bus_if.is_imm = v.is_imm;
    bus_if.funct3 = v.f3;
    bus_if.funct7 = v.f7;
    exp_q.push_back(v.exp);
  endtask

  task automatic check_pop(input string nm);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got %h expected scoreboard entry", nm, bus_if.out);
    end else begin
      e = exp_q.pop_front();
      chk(nm, bus_if.out, e);
    end
  endtask

  // Apply one vector and compare once its result is due
  task automatic apply(input vec_t v, input string nm);
`ifdef ALU_OUT_REG_EN
    @(negedge clk);
    drive(v);
    @(posedge clk);
    #1;
    check_pop(nm);
`else
    drive(v);
    #1;
    check_pop(nm);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    errors = 0;
    checks = 0;

    vecs[0]  = '{32'd5,          32'd7,          1'b0, 3'b000, 7'h20, 32'hFFFF_FFFE};
    vecs[1]  = '{32'd5,          32'd7,          1'b1, 3'b000, 7'h20, 32'h0000_000C};
    vecs[2]  = '{32'h8000_0000,  32'h0000_0404,  1'b1, 3'b101, 7'h20, 32'hF800_0000};
    vecs[3]  = '{32'h8000_0000,  32'h0000_0004,  1'b1, 3'b101, 7'h00, 32'h0800_0000};
    vecs[4]  = '{32'hFFFF_FFFF,  32'd1,          1'b0, 3'b010, 7'h00, 32'd1};
    vecs[5]  = '{32'hFFFF_FFFF,  32'd1,          1'b0, 3'b011, 7'h00, 32'd0};
    vecs[6]  = '{32'd1,          32'h0000_003F,  1'b0, 3'b001, 7'h20, 32'h8000_0000};
    vecs[7]  = '{32'hF0F0_F0F0,  32'h0FF0_0FF0,  1'b0, 3'b100, 7'h00, 32'hFF00_FF00};
    vecs[8]  = '{32'hF0F0_F0F0,  32'h0FF0_0FF0,  1'b0, 3'b110, 7'h00, 32'hFFF0_FFF0};
    vecs[9]  = '{32'hF0F0_F0F0,  32'h0FF0_0FF0,  1'b0, 3'b111, 7'h00, 32'h00F0_00F0};
    vecs[10] = '{32'hFFFF_FFFF,  32'd1,          1'b0, 3'b000, 7'h00, 32'h0000_0000};
    vecs[11] = '{32'h8000_0010,  32'hFFFF_FFE1,  1'b0, 3'b101, 7'h20, 32'hC000_0008};
    vecs[12] = '{32'h1234_5678,  32'h0000_0020,  1'b0, 3'b101, 7'h00, 32'h1234_5678};
    vecs[13] = '{32'd1,          32'hFFFF_FFFF,  1'b0, 3'b010, 7'h00, 32'd0};
    vecs[14] = '{32'd1,          32'hFFFF_FFFF,  1'b0, 3'b011, 7'h00, 32'd1};
    vecs[15] = '{32'hAAAA_5555,  32'hFFFF_0000,  1'b1, 3'b100, 7'h20, 32'h5555_5555};
    vecs[16] = '{32'd0,          32'd1,          1'b0, 3'b000, 7'h20, 32'hFFFF_FFFF};
    vecs[17] = '{32'h8000_0000,  32'h8000_0000,  1'b0, 3'b010, 7'h00, 32'd0};

    b2b[0] = '{32'd1, 32'd1, 1'b0, 3'b000, 7'h00, 32'd2};
    b2b[1] = '{32'd3, 32'd1, 1'b0, 3'b100, 7'h00, 32'd2};
    b2b[2] = '{32'd6, 32'd3, 1'b0, 3'b111, 7'h00, 32'd2};

    // Reset with live operands 5+7
    rst           = 1'b0;
    bus_if.in1    = 32'd5;
    bus_if.in2    = 32'd7;
    bus_if.is_imm = 1'b0;
    bus_if.funct3 = 3'b000;
    bus_if.funct7 = 7'h00;
    #1;
`ifdef ALU_OUT_REG_EN
    chk("reset_out", bus_if.out, 32'd0);
    @(posedge clk);
    #1;
    chk("reset_hold", bus_if.out, 32'd0);
    @(negedge clk);
    rst = 1'b1;
`else
    chk("reset_comb", bus_if.out, 32'd12);
    rst = 1'b1;
`endif

    for (int i = 0; i < 18; i++) begin
      apply(vecs[i], $sformatf("vec%0d", i));
    end

    // ADD 1+2 around an asynchronous reset pulse
    apply('{32'd1, 32'd2, 1'b0, 3'b000, 7'h00, 32'd3}, "add_pre_rst");
`ifdef ALU_OUT_REG_EN
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_async", bus_if.out, 32'd0);
    @(posedge clk);
    #1;
    chk("rst_hold_edge", bus_if.out, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    exp_q.push_back(32'd3);
    #1;
    chk("rst_rel_pre_edge", bus_if.out, 32'd0);
    @(posedge clk);
    #1;
    check_pop("rst_rel_post_edge");
`else
    rst = 1'b0;
    #1;
    chk("rst_no_effect", bus_if.out, 32'd3);
    rst = 1'b1;
`endif

    // Back-to-back operations, one per cycle
`ifdef ALU_OUT_REG_EN
    @(negedge clk);
    drive(b2b[0]);
    #1;
    chk("b2b_latency", bus_if.out, 32'd3);
    @(posedge clk);
    #1;
    check_pop("b2b0");
    apply(b2b[1], "b2b1");
    apply(b2b[2], "b2b2");
`else
    for (int i = 0; i < 3; i++) begin
      apply(b2b[i], $sformatf("b2b%0d", i));
    end
`endif

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-low; asserted when 0.
REQ-003 in1  input  32  operand 1 (rs1 value).
REQ-004 in2  input  32  operand 2 (rs2 value, or sign-extended I-immediate when is_imm=1).
REQ-005 is_imm  input  1  1 = OP-IMM instruction, 0 = OP (register-register) instruction.
REQ-006 funct3  input  3  RV32I funct3 operation select.
REQ-007 funct7  input  7  RV32I funct7; only bit 5 is significant.
REQ-008 out  output  32  result.

Function
REQ-009 Result per funct3: 000 ADD/SUB; 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRL/SRA; 110 OR; 111 AND.
REQ-010 Selection between ADD and SUB:
- SUB (in1 - in2) only when is_imm=0 and funct7[5]=1.
- ADD (in1 + in2) otherwise; is_imm=1 always adds regardless of funct7.
REQ-011 ADD/SUB are modulo 2^32; carry and overflow are discarded.
REQ-012 Shift amount is in2[4:0] for every shift; in2[31:5] are ignored.
REQ-013 funct3=101 with funct7[5]=1 is an arithmetic right shift (sign fill), for both is_imm values.
REQ-014 funct3=101 with funct7[5]=0 is a logical right shift (zero fill).
REQ-015 funct3=001 ignores funct7.
REQ-016 SLT: out = 32'd1 if signed(in1) < signed(in2), else 32'd0.
REQ-017 SLTU: same as SLT, using an unsigned compare.
REQ-018 XOR/OR/AND are bitwise and ignore funct7 and is_imm.
REQ-019 The result is a pure function of the current in1, in2, is_imm, funct3 and funct7; no internal state other than the output register (REQ-020).
REQ-020 With ALU_OUT_REG_EN defined, out is registered: one-cycle latency, and out is loaded every rising clk edge from the inputs present before that edge.
REQ-021 No handshake: the ALU accepts new operands every cycle. Throughput is 1 result per cycle; latency is 1 cycle when registered, 0 cycles when combinational.
REQ-022 X/undefined encodings do not exist: every funct3/funct7/is_imm combination yields a defined result as above.

Reset
REQ-023 When rst=0 and ALU_OUT_REG_EN is defined, out is forced to 32'h0000_0000 immediately, independent of clk.
REQ-024 When rst=0, out holds 0 until the first rising clk edge after rst returns to 1. That edge loads the result of the then-present inputs.
REQ-025 Reset asserted mid-operation discards the pending result; it is not recovered after release.
REQ-026 Without ALU_OUT_REG_EN, rst has no effect; out tracks the inputs combinationally at all times.

Configuration
REQ-027 Macro ALU_OUT_REG_EN defined: output register present, 1-cycle latency, asynchronous reset to 0 per REQ-023.
REQ-028 Macro ALU_OUT_REG_EN undefined: out is purely combinational from the inputs, 0-cycle latency; clk and rst are unused but remain ports.
REQ-029 The function table (REQ-009..REQ-018) is identical in both configurations.

Verification
REQ-030 Scenario: is_imm=0, funct3=000, funct7=0x20, in1=5, in2=7 -> out=0xFFFFFFFE. The same stimulus with is_imm=1 -> out=0x0000000C.
REQ-031 Scenario: funct3=101, in1=0x80000000, in2=0x404 (I-imm with bit10 set, so funct7[5]=1, shamt=4), is_imm=1 -> out=0xF8000000. The same with funct7=0, in2=4 -> out=0x08000000.
REQ-032 Scenario: funct3=010, in1=0xFFFFFFFF, in2=1 -> out=1. funct3=011 with the same operands -> out=0.
REQ-033 Scenario: funct3=001, in1=1, in2=0x0000003F -> out=0x80000000 (only shamt 31 used). funct3=100/110/111 with in1=0xF0F0F0F0, in2=0x0FF00FF0 -> 0xFF00FF00 / 0xFFF0FFF0 / 0x00F000F0.
REQ-034 Scenario (registered build): drive ADD 1+2, assert rst=0 between clock edges -> out=0 immediately. Release rst -> out=3 after the next rising edge and not before.
REQ-035 Scenario (registered build): back-to-back ops each cycle (ADD 1+1, then XOR 3^1, then AND 6&3) -> out=2, 2, 2 on successive edges, each result appearing exactly one cycle after its inputs.
